// File: rtl/sample_framer_pkg.sv
// Shared types and constants for the sample framer.
// SAMPLE_FRAMER_CSUM_EN adds the trailing checksum state.
package sample_framer_pkg;

    typedef enum logic [3:0] {
        S_IDLE,
        S_SYNC0,
        S_SYNC1,
        S_LEN,
        S_SEQ,
        S_RD,
        S_CAP,
        S_DHI,
`ifdef SAMPLE_FRAMER_CSUM_EN
        S_DLO,
        S_CSUM
`else
        S_DLO
`endif
    } state_t;

    localparam logic [7:0] DEF_SYNC0 = 8'hA5;
    localparam logic [7:0] DEF_SYNC1 = 8'h5A;

endpackage

// File: rtl/framer_csum.sv
// 8-bit modular byte accumulator for the frame checksum.
// Clear has priority over add.
module framer_csum (
    input  logic       clk,
    input  logic       rst,
    input  logic       clr,
    input  logic       add,
    input  logic [7:0] din,
    output logic [7:0] sum
);

    // accumulate bytes mod 256, restart on clear
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            sum <= '0;
        end else if (clr) begin
            sum <= '0;
        end else if (add) begin
            sum <= sum + din;
        end
    end

endmodule

// File: rtl/sample_framer.sv
// Packs 12-bit FIFO samples into a byte frame with a sync header.
// SAMPLE_FRAMER_CSUM_EN appends a checksum byte to each frame.
module sample_framer
    import sample_framer_pkg::*;
#(
    parameter int unsigned FRAME_SAMPLES = 16,
    parameter logic [7:0]  SYNC0         = DEF_SYNC0,
    parameter logic [7:0]  SYNC1         = DEF_SYNC1
) (
    input  logic        fifo_1_clk,
    input  logic        rst,
    input  logic        fifo_empty,
    input  logic [11:0] fifo_dout,
    output logic        fifo_rd_en,
    output logic [7:0]  tx_data,
    output logic        tx_valid,
    input  logic        tx_ready,
    output logic        busy,
    output logic        frame_done
);

    localparam logic [7:0] LEN = FRAME_SAMPLES[7:0];

    state_t      state;
    state_t      state_nxt;
    logic [7:0]  seq;
    logic [7:0]  cnt;
    logic [11:0] sample;
    logic        last;
    logic        acc;

    assign last = (cnt == LEN - 8'd1);
    assign acc  = tx_valid && tx_ready;
    assign busy = (state != S_IDLE);

`ifdef SAMPLE_FRAMER_CSUM_EN
    logic [7:0] csum;
    logic       csum_add;

    // payload bytes and LEN/SEQ feed the checksum as they are accepted
    always_comb begin
        csum_add = 1'b0;
        if (acc) begin
            unique case (state)
                S_LEN, S_SEQ, S_DHI, S_DLO: csum_add = 1'b1;
                default:                    csum_add = 1'b0;
            endcase
        end
    end

    framer_csum u_csum (
        .clk (fifo_1_clk),
        .rst (rst),
        .clr (state == S_SYNC0),
        .add (csum_add),
        .din (tx_data),
        .sum (csum)
    );
`endif

    // state, sequence number, sample counter and sample register
    always_ff @(posedge fifo_1_clk or posedge rst) begin
        if (rst) begin
            state  <= S_IDLE;
            seq    <= '0;
            cnt    <= '0;
            sample <= '0;
        end else begin
            state <= state_nxt;
            if (state == S_CAP) begin
                sample <= fifo_dout;
            end
            if (state == S_SYNC0) begin
                cnt <= '0;
            end else if (state == S_DLO && acc) begin
                cnt <= cnt + 8'd1;
            end
            if (frame_done) begin
                seq <= seq + 8'd1;
            end
        end
    end

    // next state and byte-stream outputs, held steady while stalled
    always_comb begin
        state_nxt  = state;
        tx_valid   = 1'b0;
        tx_data    = 8'h00;
        fifo_rd_en = 1'b0;
        frame_done = 1'b0;
        unique case (state)
            S_IDLE: begin
                if (!fifo_empty) state_nxt = S_SYNC0;
            end
            S_SYNC0: begin
                tx_valid = 1'b1;
                tx_data  = SYNC0;
                if (tx_ready) state_nxt = S_SYNC1;
            end
            S_SYNC1: begin
                tx_valid = 1'b1;
                tx_data  = SYNC1;
                if (tx_ready) state_nxt = S_LEN;
            end
            S_LEN: begin
                tx_valid = 1'b1;
                tx_data  = LEN;
                if (tx_ready) state_nxt = S_SEQ;
            end
            S_SEQ: begin
                tx_valid = 1'b1;
                tx_data  = seq;
                if (tx_ready) state_nxt = S_RD;
            end
            S_RD: begin
                if (!fifo_empty) begin
                    fifo_rd_en = 1'b1;
                    state_nxt  = S_CAP;
                end
            end
            S_CAP: begin
                state_nxt = S_DHI;
            end
            S_DHI: begin
                tx_valid = 1'b1;
                tx_data  = {4'h0, sample[11:8]};
                if (tx_ready) state_nxt = S_DLO;
            end
            S_DLO: begin
                tx_valid = 1'b1;
                tx_data  = sample[7:0];
                if (tx_ready) begin
                    if (!last) begin
                        state_nxt = S_RD;
                    end else begin
`ifdef SAMPLE_FRAMER_CSUM_EN
                        state_nxt = S_CSUM;
`else
                        state_nxt  = S_IDLE;
                        frame_done = 1'b1;
`endif
                    end
                end
            end
`ifdef SAMPLE_FRAMER_CSUM_EN
            S_CSUM: begin
                tx_valid = 1'b1;
                tx_data  = csum;
                if (tx_ready) begin
                    state_nxt  = S_IDLE;
                    frame_done = 1'b1;
                end
            end
`endif
            default: begin
                state_nxt = S_IDLE;
            end
        endcase
    end

endmodule

// File: tb/tb_sample_framer.sv
// Directed bench for sample_framer with a FIFO model and byte monitor.
// Honours SAMPLE_FRAMER_CSUM_EN for the expected trailing byte.
module tb_sample_framer;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        fifo_empty;
    logic [11:0] fifo_dout = '0;
    logic        fifo_rd_en;
    logic [7:0]  tx_data;
    logic        tx_valid;
    logic        tx_ready = 1'b1;
    logic        busy;
    logic        frame_done;

    int n_cmp = 0;
    int n_bad = 0;

    logic [11:0] mem [0:1023];
    int          wp = 0;
    int          rp = 0;
    logic        hold_empty = 1'b0;
    logic        rnd_mode = 1'b0;
    logic        ready_fix = 1'b1;

    logic [7:0] cur [$];
    logic [7:0] frm [$];
    int         done_cnt = 0;
    int         busy_cyc = 0;
    int         frm_busy = 0;
    logic       stall_v = 1'b0;
    logic [7:0] stall_d = '0;

    always #5 clk = ~clk;

    assign fifo_empty = hold_empty || (wp == rp);

    sample_framer #(.FRAME_SAMPLES(2)) dut (
        .fifo_1_clk (clk),
        .rst        (rst),
        .fifo_empty (fifo_empty),
        .fifo_dout  (fifo_dout),
        .fifo_rd_en (fifo_rd_en),
        .tx_data    (tx_data),
        .tx_valid   (tx_valid),
        .tx_ready   (tx_ready),
        .busy       (busy),
        .frame_done (frame_done)
    );

    task automatic chk(input string tag, input logic [31:0] got,
                       input logic [31:0] exp);
        n_cmp++;
        if (got !== exp) begin
            n_bad++;
            $display("FAIL %s: got %0h want %0h", tag, got, exp);
        end
    endtask

    // FIFO read port: data appears one cycle after the strobe
    always @(posedge clk) begin
        if (fifo_rd_en) begin
            fifo_dout <= mem[rp % 1024];
            rp <= rp + 1;
        end
    end

    // downstream sink readiness, optionally randomised
    initial begin
        forever begin
            @(posedge clk);
            #1;
            tx_ready = rnd_mode ? 1'($urandom_range(0, 1)) : ready_fix;
        end
    end

    // byte monitor and per-cycle protocol checks
    always @(negedge clk) begin
        if (rst) begin
            cur.delete();
            stall_v = 1'b0;
            busy_cyc = 0;
        end else begin
            if (stall_v) begin
                chk("stall_valid", 32'(tx_valid), 32'd1);
                chk("stall_data", 32'(tx_data), 32'(stall_d));
            end
            chk("rd_guard", 32'(fifo_rd_en & fifo_empty), 32'd0);
            if (busy) busy_cyc++;
            if (tx_valid && tx_ready) cur.push_back(tx_data);
            if (frame_done) begin
                chk("done_acc", 32'(tx_valid & tx_ready), 32'd1);
                frm = cur;
                cur.delete();
                frm_busy = busy_cyc;
                busy_cyc = 0;
                done_cnt++;
            end
            stall_v = tx_valid && !tx_ready;
            stall_d = tx_data;
        end
    end

    task automatic tick(input int n);
        repeat (n) begin
            @(posedge clk);
            #1;
        end
    endtask

    task automatic push(input logic [11:0] d);
        mem[wp % 1024] = d;
        wp = wp + 1;
    endtask

    task automatic wait_frame(input int start);
        int k;
        k = 0;
        while (done_cnt <= start && k < 400) begin
            tick(1);
            k++;
        end
        if (done_cnt <= start) chk("timeout", 32'd0, 32'd1);
    endtask

    task automatic check_frame(input string tag, input logic [7:0] sq,
                               input logic [11:0] s0, input logic [11:0] s1);
        logic [7:0] exp [$];
        logic [7:0] sum;
        exp.push_back(8'hA5);
        exp.push_back(8'h5A);
        exp.push_back(8'h02);
        exp.push_back(sq);
        exp.push_back({4'h0, s0[11:8]});
        exp.push_back(s0[7:0]);
        exp.push_back({4'h0, s1[11:8]});
        exp.push_back(s1[7:0]);
        sum = 8'h02 + sq + {4'h0, s0[11:8]} + s0[7:0]
            + {4'h0, s1[11:8]} + s1[7:0];
`ifdef SAMPLE_FRAMER_CSUM_EN
        exp.push_back(sum);
`endif
        chk({tag, "_nbytes"}, 32'(frm.size()), 32'(exp.size()));
        for (int i = 0; i < exp.size(); i++) begin
            if (i < frm.size())
                chk($sformatf("%s_b%0d", tag, i), 32'(frm[i]), 32'(exp[i]));
        end
    endtask

    initial begin
        int d0;
        int k;
        int frame_cyc;
`ifdef SAMPLE_FRAMER_CSUM_EN
        frame_cyc = 13;
`else
        frame_cyc = 12;
`endif
        tick(3);
        chk("rst_valid", 32'(tx_valid), 32'd0);
        chk("rst_data", 32'(tx_data), 32'd0);
        chk("rst_rd", 32'(fifo_rd_en), 32'd0);
        chk("rst_busy", 32'(busy), 32'd0);
        chk("rst_done", 32'(frame_done), 32'd0);
        rst = 1'b0;
        tick(2);
        chk("idle_busy", 32'(busy), 32'd0);

        // basic frame, sink always ready
        d0 = done_cnt;
        push(12'h123);
        push(12'hABC);
        wait_frame(d0);
        check_frame("f0", 8'h00, 12'h123, 12'hABC);
        chk("f0_cycles", 32'(frm_busy), 32'(frame_cyc));
        tick(4);
        chk("f0_once", 32'(done_cnt - d0), 32'd1);
        chk("f0_idle", 32'(busy), 32'd0);

        // random backpressure
        rnd_mode = 1'b1;
        d0 = done_cnt;
        push(12'h123);
        push(12'hABC);
        wait_frame(d0);
        rnd_mode = 1'b0;
        check_frame("f1", 8'h01, 12'h123, 12'hABC);
        tick(2);

        // FIFO runs dry after the first sample
        d0 = done_cnt;
        push(12'h123);
        k = 0;
        while (cur.size() < 6 && k < 100) begin
            tick(1);
            k++;
        end
        tick(5);
        chk("dry_valid", 32'(tx_valid), 32'd0);
        chk("dry_rd", 32'(fifo_rd_en), 32'd0);
        chk("dry_busy", 32'(busy), 32'd1);
        push(12'hABC);
        wait_frame(d0);
        check_frame("f2", 8'h02, 12'h123, 12'hABC);
        tick(2);

        // reset in the middle of the second frame after a fresh reset
        rst = 1'b1;
        tick(2);
        rst = 1'b0;
        tick(1);
        d0 = done_cnt;
        push(12'h123);
        push(12'hABC);
        wait_frame(d0);
        check_frame("r0", 8'h00, 12'h123, 12'hABC);
        tick(2);
        push(12'h123);
        push(12'hABC);
        k = 0;
        while (!(cur.size() == 4 && tx_valid) && k < 100) begin
            @(negedge clk);
            k++;
        end
        chk("r1_dhi", 32'(tx_data), 32'h01);
        rst = 1'b1;
        #1;
        chk("mid_valid", 32'(tx_valid), 32'd0);
        chk("mid_data", 32'(tx_data), 32'd0);
        chk("mid_rd", 32'(fifo_rd_en), 32'd0);
        chk("mid_busy", 32'(busy), 32'd0);
        chk("mid_done", 32'(frame_done), 32'd0);
        wp = rp;
        tick(2);
        rst = 1'b0;
        tick(1);
        d0 = done_cnt;
        push(12'h123);
        push(12'hABC);
        wait_frame(d0);
        check_frame("r2", 8'h00, 12'h123, 12'hABC);
        tick(2);

        // 257 back-to-back frames: SEQ 01..FF then wraps to 00
        for (int f = 1; f <= 257; f++) begin
            d0 = done_cnt;
            push(12'(f));
            push(12'hFFF - 12'(f));
            wait_frame(d0);
            if (frm.size() > 3)
                chk($sformatf("seq%0d", f), 32'(frm[3]), 32'(f % 256));
            @(negedge clk);
            chk($sformatf("gap%0d", f), 32'(busy), 32'd0);
            tick(1);
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***",
                 n_cmp, n_bad);
        $finish;
    end

endmodule
